// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and counter-width helper for the button front end
package button_pkg;
  typedef enum logic [1:0] {IDLE, ARMING, HELD, DISARMING} btn_state_t;
  function automatic int cnt_width(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: one button lane - pad synchronizer, stable-count debounce FSM, auto-repeat
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 10000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bi,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic bo
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = cnt_width(RMAX + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DELAY = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE - 1);
  localparam logic PAD_IDLE = (ACTIVE_LOW != 0);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic rep_run_q, rep_run_d;
  logic level_q, level_d, press_q, press_d, rel_q, rel_d, rpt_q, rpt_d, bo_q, bo_d;
  logic s;
  assign s = sync_q[SYNC_STAGES-1] ^ PAD_IDLE;
  // next-state: debounce FSM, repeat cadence (first gap REPEAT_DELAY, then REPEAT_RATE), strobes
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bi};
    state_d = state_q;
    cnt_d = cnt_q;
    rcnt_d = rcnt_q;
    rep_run_d = rep_run_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    rpt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s && DEBOUNCE_CYCLES == 1) begin
          state_d = HELD;
          press_d = 1'b1;
          rcnt_d = '0;
          rep_run_d = 1'b0;
        end else if (s) begin
          state_d = ARMING;
          cnt_d = CW'(1);
        end
      end
      ARMING: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
          state_d = HELD;
          cnt_d = '0;
          press_d = 1'b1;
          rcnt_d = '0;
          rep_run_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (REPEAT_DELAY > 0) begin
          rpt_d = (rcnt_q == (rep_run_q ? R_RATE : R_DELAY));
          rcnt_d = rpt_d ? '0 : rcnt_q + 1'b1;
          rep_run_d = rep_run_q | rpt_d;
        end
        if (!s && DEBOUNCE_CYCLES == 1) begin
          state_d = IDLE;
          rel_d = 1'b1;
          rcnt_d = '0;
          rep_run_d = 1'b0;
        end else if (!s) begin
          state_d = DISARMING;
          cnt_d = CW'(1);
        end
      end
      DISARMING: begin
        if (s) begin
          state_d = HELD;
          cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
          state_d = IDLE;
          cnt_d = '0;
          rel_d = 1'b1;
          rcnt_d = '0;
          rep_run_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == HELD) || (state_d == DISARMING);
    bo_d = press_d | rpt_d;
  end
  // state and registered outputs; sync chain resets to the idle pad level so reset release is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{PAD_IDLE}};
      state_q <= IDLE;
      cnt_q <= '0;
      rcnt_q <= '0;
      rep_run_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      rpt_q <= 1'b0;
      bo_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      rcnt_q <= rcnt_d;
      rep_run_q <= rep_run_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
      rpt_q <= rpt_d;
      bo_q <= bo_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
  assign rel = rel_q;
  assign rpt = rpt_q;
  assign bo = bo_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_CH independent debounced button channels with press/release/repeat strobes
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 10000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [N_CH-1:0] Bi,
  output logic [N_CH-1:0] Level,
  output logic [N_CH-1:0] Press,
  output logic [N_CH-1:0] Release,
  output logic [N_CH-1:0] Repeat,
  output logic [N_CH-1:0] Bo
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk(Clock),
      .rst_n(Resetn),
      .bi(Bi[i]),
      .level(Level[i]),
      .press(Press[i]),
      .rel(Release[i]),
      .rpt(Repeat[i]),
      .bo(Bo[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenario checks of the two-channel button conditioner
module tb_button_conditioner;
  logic Clock = 1'b0;
  logic Resetn;
  logic [1:0] Bi, Level, Press, Release, Repeat, Bo;
  int checks = 0;
  int failures = 0;

  button_conditioner #(
    .N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .ACTIVE_LOW(1)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Bi(Bi), .Level(Level),
    .Press(Press), .Release(Release), .Repeat(Repeat), .Bo(Bo)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset;
    Bi = 2'b11;
    Resetn = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic test_reset;
    Bi = 2'b11;
    Resetn = 1'b0;
    #2;
    tick();
    checks++;
    if ({Level, Press, Release, Repeat, Bo} !== 10'b0) begin
      failures++;
      $display("FAIL reset_held got=%b want=%b", {Level, Press, Release, Repeat, Bo}, 10'b0);
    end
    Resetn = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== 10'b0) begin
        failures++;
        $display("FAIL reset_idle t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, 10'b0);
      end
    end
  endtask

  task automatic test_clean_press;
    logic [1:0] lv, pr, rl, rp;
    apply_reset();
    Bi = 2'b10;
    for (int t = 1; t <= 8; t++) begin
      tick();
      lv = {1'b0, t >= 6};
      pr = {1'b0, t == 6};
      rl = 2'b00;
      rp = 2'b00;
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== {lv, pr, rl, rp, pr | rp}) begin
        failures++;
        $display("FAIL clean_press t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, {lv, pr, rl, rp, pr | rp});
      end
    end
    Bi = 2'b11;
    for (int t = 1; t <= 8; t++) begin
      tick();
      lv = {1'b0, t < 6};
      pr = 2'b00;
      rl = {1'b0, t == 6};
      rp = 2'b00;
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== {lv, pr, rl, rp, pr | rp}) begin
        failures++;
        $display("FAIL clean_release t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, {lv, pr, rl, rp, pr | rp});
      end
    end
  endtask

  task automatic test_bounce;
    logic [1:0] lv, pr, rl, rp;
    apply_reset();
    for (int t = 1; t <= 12; t++) begin
      Bi = {1'b1, t == 4};
      tick();
      lv = {1'b0, t >= 10};
      pr = {1'b0, t == 10};
      rl = 2'b00;
      rp = 2'b00;
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== {lv, pr, rl, rp, pr | rp}) begin
        failures++;
        $display("FAIL bounce t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, {lv, pr, rl, rp, pr | rp});
      end
    end
  endtask

  task automatic test_auto_repeat;
    logic [1:0] lv, pr, rl, rp;
    apply_reset();
    for (int t = 1; t <= 50; t++) begin
      Bi = {1'b1, t > 40};
      tick();
      lv = {1'b0, t >= 6 && t < 46};
      pr = {1'b0, t == 6};
      rl = {1'b0, t == 46};
      rp = {1'b0, t >= 16 && t <= 43 && (t - 16) % 3 == 0};
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== {lv, pr, rl, rp, pr | rp}) begin
        failures++;
        $display("FAIL auto_repeat t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, {lv, pr, rl, rp, pr | rp});
      end
    end
  endtask

  task automatic test_release_glitch;
    logic [1:0] lv, pr, rl, rp;
    apply_reset();
    for (int t = 1; t <= 36; t++) begin
      Bi = {1'b1, t == 20 || t == 21};
      tick();
      lv = {1'b0, t >= 6};
      pr = {1'b0, t == 6};
      rl = 2'b00;
      rp = {1'b0, (t >= 16 && t <= 22 && (t - 16) % 3 == 0) || (t >= 27 && (t - 27) % 3 == 0)};
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== {lv, pr, rl, rp, pr | rp}) begin
        failures++;
        $display("FAIL release_glitch t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, {lv, pr, rl, rp, pr | rp});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] lv, pr, rl, rp;
    apply_reset();
    Bi = 2'b10;
    for (int t = 1; t <= 4; t++) tick();
    Resetn = 1'b0;
    #1;
    checks++;
    if ({Level, Press, Release, Repeat, Bo} !== 10'b0) begin
      failures++;
      $display("FAIL reset_mid_arming got=%b want=%b", {Level, Press, Release, Repeat, Bo}, 10'b0);
    end
    Bi = 2'b01;
    tick();
    tick();
    Resetn = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      lv = {t >= 6, 1'b0};
      pr = {t == 6, 1'b0};
      rl = 2'b00;
      rp = {t == 16, 1'b0};
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== {lv, pr, rl, rp, pr | rp}) begin
        failures++;
        $display("FAIL held_through_reset t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, {lv, pr, rl, rp, pr | rp});
      end
    end
    Resetn = 1'b0;
    #1;
    checks++;
    if ({Level, Press, Release, Repeat, Bo} !== 10'b0) begin
      failures++;
      $display("FAIL reset_mid_repeat got=%b want=%b", {Level, Press, Release, Repeat, Bo}, 10'b0);
    end
    Bi = 2'b11;
    tick();
    tick();
    Resetn = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== 10'b0) begin
        failures++;
        $display("FAIL reset_quiet t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, 10'b0);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [1:0] lv, pr, rl, rp;
    apply_reset();
    for (int t = 1; t <= 20; t++) begin
      Bi = {t >= 11, t >= 9};
      tick();
      lv = {t >= 6 && t < 16, t >= 6 && t < 14};
      pr = {t == 6, t == 6};
      rl = {t == 16, t == 14};
      rp = 2'b00;
      checks++;
      if ({Level, Press, Release, Repeat, Bo} !== {lv, pr, rl, rp, pr | rp}) begin
        failures++;
        $display("FAIL simultaneous t=%0d got=%b want=%b", t, {Level, Press, Release, Repeat, Bo}, {lv, pr, rl, rp, pr | rp});
      end
    end
  endtask

  initial begin
    Resetn = 1'b0;
    Bi = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_glitch();
    test_reset_mid();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
